// File: rtl/adc_control_nonbinary_param.sv
// adc_control_nonbinary_param
// SAR sequencer for a redundant (non-binary) capacitor DAC.
// Flow: IDLE -> SAMPLE -> CONVERT (coarse steps, then fine steps) -> HOLD.
// Each decided step sets its P/N switch pair and, on a 1 decision, adds
// that step's weight into a saturating accumulator. The finished result is
// offered through a valid/ready handshake with a sticky overrun flag.
//
// Build option: define ADC_CTRL_OVERSAMPLE_EN to enable majority-vote
// oversampling on the fine steps (OSR = 2^(a+1)-1 comparator samples per
// fine step, a = clamped avg_control_in). Without it every step takes one
// cycle, avg_control_in is ignored and no vote counter is built.
module adc_control_nonbinary_param #(
  parameter int NUM_STEPS    = 15,
  parameter int FINE_STEPS   = 4,
  parameter int RESULT_BITS  = 12,
  parameter int AVG_BITS     = 3,
  parameter int MAX_AVG_LOG2 = 5,
  parameter logic [NUM_STEPS*RESULT_BITS-1:0] WEIGHTS = {
    12'd2048, 12'd806, 12'd486, 12'd293, 12'd176,
    12'd106,  12'd64,  12'd38,  12'd23,  12'd14,
    12'd8,    12'd6,   12'd4,   12'd2,   12'd1
  }
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_in,
  input  logic                   continuous_in,
  input  logic                   comparator_in,
  input  logic [AVG_BITS-1:0]    avg_control_in,
  output logic                   sample_out,
  output logic                   sample_out_n,
  output logic                   enable_loop_out,
  output logic                   busy_out,
  output logic                   conv_finished_strobe_out,
  output logic [NUM_STEPS-1:0]   pswitch_out,
  output logic [NUM_STEPS-1:0]   nswitch_out,
  output logic [RESULT_BITS-1:0] result_out,
  output logic                   result_valid_out,
  input  logic                   result_ready_in,
  output logic                   overrun_out
);

  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [SW-1:0]          step_reg, step_next;
  logic [RESULT_BITS-1:0] acc_reg, acc_next;
  logic [NUM_STEPS-1:0]   psw_reg, psw_next;
  logic [NUM_STEPS-1:0]   nsw_reg, nsw_next;
  logic [RESULT_BITS-1:0] result_reg, result_next;
  logic                   valid_reg, valid_next;
  logic                   overrun_reg, overrun_next;
  logic                   load_result;

  // Per-step weight table, unpacked so step 0 takes the most significant slice
  logic [RESULT_BITS-1:0] weight_tab [NUM_STEPS];

  generate
    for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_weight
      assign weight_tab[gi] = WEIGHTS[(NUM_STEPS-1-gi)*RESULT_BITS +: RESULT_BITS];
    end
  endgenerate

  // Step k drives switch bit NUM_STEPS-1-k, so the MSB step lands on the MSB
  logic [SW-1:0]        sw_idx;
  logic [RESULT_BITS:0] sum_ext;
  logic [RESULT_BITS-1:0] acc_sat;

  assign sw_idx  = LAST_STEP - step_reg;
  assign sum_ext = {1'b0, acc_reg} + {1'b0, weight_tab[step_reg]};
  assign acc_sat = sum_ext[RESULT_BITS] ? {RESULT_BITS{1'b1}} : sum_ext[RESULT_BITS-1:0];

  // step_done marks the last cycle of the current step; decision is its outcome
  logic step_done;
  logic decision;

`ifdef ADC_CTRL_OVERSAMPLE_EN
  localparam int COARSE_STEPS = NUM_STEPS - FINE_STEPS;
  // Wide enough for 2^(MAX_AVG_LOG2+1)
  localparam int CW = MAX_AVG_LOG2 + 2;
  localparam int AW = (MAX_AVG_LOG2 > 0) ? $clog2(MAX_AVG_LOG2 + 1) : 1;

  logic [CW-1:0] sub_reg, sub_next;    // sample index inside a fine step
  logic [CW-1:0] ones_reg, ones_next;  // ones seen so far inside a fine step
  logic [AW-1:0] avg_reg, avg_next;    // clamped oversampling code
  logic          is_fine;
  logic [CW-1:0] ones_total;
  logic [CW-1:0] threshold;
  logic [CW-1:0] osr_last;

  // Strict majority of 2^(a+1)-1 samples means at least 2^a ones
  assign is_fine    = (step_reg >= SW'(COARSE_STEPS));
  assign ones_total = ones_reg + CW'(comparator_in);
  assign threshold  = CW'(1) << avg_reg;
  assign osr_last   = (threshold << 1) - CW'(2);
  assign step_done  = !is_fine || (sub_reg == osr_last);
  assign decision   = is_fine ? (ones_total >= threshold) : comparator_in;
`else
  logic avg_unused;

  assign avg_unused = ^avg_control_in;
  assign step_done  = 1'b1;
  assign decision   = comparator_in;
`endif

  // Next-state, datapath and handshake logic
  always_comb begin
    state_next   = state_reg;
    step_next    = step_reg;
    acc_next     = acc_reg;
    psw_next     = psw_reg;
    nsw_next     = nsw_reg;
    result_next  = result_reg;
    valid_next   = valid_reg;
    overrun_next = overrun_reg;
    load_result  = 1'b0;
`ifdef ADC_CTRL_OVERSAMPLE_EN
    sub_next     = sub_reg;
    ones_next    = ones_reg;
    avg_next     = avg_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (start_in || continuous_in) begin
          state_next = SAMPLE;
        end
      end

      SAMPLE: begin
        step_next  = '0;
        acc_next   = '0;
        psw_next   = '0;
        nsw_next   = '0;
        state_next = CONVERT;
`ifdef ADC_CTRL_OVERSAMPLE_EN
        sub_next  = '0;
        ones_next = '0;
        if (int'(avg_control_in) > MAX_AVG_LOG2) begin
          avg_next = AW'(MAX_AVG_LOG2);
        end else begin
          avg_next = AW'(avg_control_in);
        end
`endif
      end

      CONVERT: begin
`ifdef ADC_CTRL_OVERSAMPLE_EN
        if (step_done) begin
          sub_next  = '0;
          ones_next = '0;
        end else begin
          sub_next  = sub_reg + CW'(1);
          ones_next = ones_total;
        end
`endif
        if (step_done) begin
          psw_next[sw_idx] = decision;
          nsw_next[sw_idx] = ~decision;
          if (decision) begin
            acc_next = acc_sat;
          end
          if (step_reg == LAST_STEP) begin
            state_next  = HOLD;
            load_result = 1'b1;
          end else begin
            step_next = step_reg + SW'(1);
          end
        end
      end

      HOLD: begin
        state_next = continuous_in ? SAMPLE : IDLE;
      end

      default: state_next = IDLE;
    endcase

    // The result register is loaded on the edge entering HOLD so it is
    // already visible while the strobe is high. A fresh result beats a
    // same-cycle consume; an unconsumed older result is lost -> overrun.
    if (load_result) begin
      result_next = acc_next;
      valid_next  = 1'b1;
      if (valid_reg && !result_ready_in) begin
        overrun_next = 1'b1;
      end
    end else if (valid_reg && result_ready_in) begin
      valid_next = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      step_reg    <= '0;
      acc_reg     <= '0;
      psw_reg     <= '0;
      nsw_reg     <= '0;
      result_reg  <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
`ifdef ADC_CTRL_OVERSAMPLE_EN
      sub_reg     <= '0;
      ones_reg    <= '0;
      avg_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      step_reg    <= step_next;
      acc_reg     <= acc_next;
      psw_reg     <= psw_next;
      nsw_reg     <= nsw_next;
      result_reg  <= result_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
`ifdef ADC_CTRL_OVERSAMPLE_EN
      sub_reg     <= sub_next;
      ones_reg    <= ones_next;
      avg_reg     <= avg_next;
`endif
    end
  end

  // Status outputs decode straight from the state register
  assign sample_out               = (state_reg == SAMPLE);
  assign sample_out_n             = ~sample_out;
  assign enable_loop_out          = (state_reg == CONVERT);
  assign busy_out                 = (state_reg != IDLE);
  assign conv_finished_strobe_out = (state_reg == HOLD);

  assign pswitch_out      = psw_reg;
  assign nswitch_out      = nsw_reg;
  assign result_out       = result_reg;
  assign result_valid_out = valid_reg;
  assign overrun_out      = overrun_reg;

endmodule

// File: tb/tb_adc_control_nonbinary_param.sv
// Directed testbench for adc_control_nonbinary_param.
// Expected results are hand-computed per vector; where the oversampling
// build option changes the answer both values are listed.
module tb_adc_control_nonbinary_param;

  localparam int NSTEPS = 15;
  localparam int COARSE = 11;

`ifdef ADC_CTRL_OVERSAMPLE_EN
  localparam bit OS = 1'b1;
`else
  localparam bit OS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic        continuous_in;
  logic        comparator_in;
  logic [2:0]  avg_control_in;
  logic        result_ready_in;

  logic        sample_out, sample_out_n, enable_loop_out, busy_out, strobe;
  logic [14:0] pswitch_out, nswitch_out;
  logic [11:0] result_out;
  logic        result_valid_out, overrun_out;

  // Second instance with oversized weights, to exercise saturation
  logic        s_sample, s_sample_n, s_enable, s_busy, s_strobe;
  logic [14:0] s_psw, s_nsw;
  logic [11:0] s_result;
  logic        s_valid, s_overrun;

  int vec_count = 0;
  int err_count = 0;
  int votes [NSTEPS];
  int osr = 1;

  always #5 clk = ~clk;

  adc_control_nonbinary_param dut (
    .clk                      (clk),
    .rst                      (rst),
    .start_in                 (start_in),
    .continuous_in            (continuous_in),
    .comparator_in            (comparator_in),
    .avg_control_in           (avg_control_in),
    .sample_out               (sample_out),
    .sample_out_n             (sample_out_n),
    .enable_loop_out          (enable_loop_out),
    .busy_out                 (busy_out),
    .conv_finished_strobe_out (strobe),
    .pswitch_out              (pswitch_out),
    .nswitch_out              (nswitch_out),
    .result_out               (result_out),
    .result_valid_out         (result_valid_out),
    .result_ready_in          (result_ready_in),
    .overrun_out              (overrun_out)
  );

  adc_control_nonbinary_param #(
    .WEIGHTS ({15{12'd2048}})
  ) dut_sat (
    .clk                      (clk),
    .rst                      (rst),
    .start_in                 (start_in),
    .continuous_in            (continuous_in),
    .comparator_in            (comparator_in),
    .avg_control_in           (avg_control_in),
    .sample_out               (s_sample),
    .sample_out_n             (s_sample_n),
    .enable_loop_out          (s_enable),
    .busy_out                 (s_busy),
    .conv_finished_strobe_out (s_strobe),
    .pswitch_out              (s_psw),
    .nswitch_out              (s_nsw),
    .result_out               (s_result),
    .result_valid_out         (s_valid),
    .result_ready_in          (result_ready_in),
    .overrun_out              (s_overrun)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s = %0d (0x%0h)", tag, got, got);
    end
  endtask

  // Comparator level for cycle c of a conversion (c=0 is SAMPLE).
  // Each fine step returns votes[k] ones followed by zeros.
  function automatic logic comp_for(input int c);
    int i, j, k, m;
    if (c < 1) return 1'b0;
    i = c - 1;
    if (i < COARSE) return (votes[i] > 0);
    j = i - COARSE;
    k = COARSE + j / osr;
    m = j % osr;
    if (k >= NSTEPS) return 1'b0;
    return (m < votes[k]);
  endfunction

  task automatic set_avg(input int a);
    int amin;
    amin = (a > 5) ? 5 : a;
    avg_control_in = 3'(a);
    osr = OS ? ((1 << (amin + 1)) - 1) : 1;
  endtask

  // Caller guarantees the next rising edge enters SAMPLE.
  // Returns at the falling edge inside HOLD.
  task automatic run_conv(input string tag, input int exp_res, input int exp_len, input bit exp_ovr);
    int c;
    int hold_c;
    c = 0;
    hold_c = -1;
    while (hold_c < 0 && c < 600) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 0) begin
        start_in = 1'b0;
        check_value({tag, " sample"}, {30'd0, sample_out, sample_out_n}, 32'd2);
      end
      comparator_in = comp_for(c);
      if (strobe) hold_c = c;
      c++;
    end
    check_value({tag, " length"}, hold_c + 1, exp_len);
    check_value({tag, " result"}, {20'd0, result_out}, exp_res);
    check_value({tag, " valid"}, {31'd0, result_valid_out}, 32'd1);
    check_value({tag, " overrun"}, {31'd0, overrun_out}, {31'd0, exp_ovr});
  endtask

  task automatic consume(input string tag);
    result_ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready_in = 1'b0;
    check_value({tag, " valid after ready"}, {31'd0, result_valid_out}, 32'd0);
  endtask

  task automatic launch(input int a);
    set_avg(a);
    start_in = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    start_in = 1'b0;
    continuous_in = 1'b0;
    comparator_in = 1'b0;
    avg_control_in = 3'd0;
    result_ready_in = 1'b0;
    repeat (2) @(negedge clk);
    check_value("reset busy/strobe/enable", {29'd0, busy_out, strobe, enable_loop_out}, 32'd0);
    check_value("reset sample pair", {30'd0, sample_out, sample_out_n}, 32'd1);
    check_value("reset switches", {2'd0, pswitch_out, nswitch_out}, 32'd0);
    check_value("reset result/valid/ovr", {18'd0, result_out, result_valid_out, overrun_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // V1: only step 0 decides 1
    votes = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    launch(0);
    run_conv("v1", 2048, 17, 1'b0);
    check_value("v1 pswitch", {17'd0, pswitch_out}, 32'h4000);
    check_value("v1 nswitch", {17'd0, nswitch_out}, 32'h3FFF);
    consume("v1");

    // V2: only step 1
    votes = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    launch(0);
    run_conv("v2", 806, 17, 1'b0);
    check_value("v2 pswitch", {17'd0, pswitch_out}, 32'h2000);
    consume("v2");

    // V3: only the four fine steps, 6+4+2+1
    votes = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    launch(0);
    run_conv("v3", 13, 17, 1'b0);
    check_value("v3 nswitch", {17'd0, nswitch_out}, 32'h7FF0);
    consume("v3");

    // V4: a=2, step 2 plus fine votes 2/7,1/7,4/7,7/7
    votes = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 4, 7};
    launch(2);
    run_conv("v4", OS ? 489 : 499, OS ? 41 : 17, 1'b0);
    check_value("v4 pswitch", {17'd0, pswitch_out}, OS ? 32'h1003 : 32'h100F);
    consume("v4");

    // V5: a=4, comparator always 1 -> full weight sum; sat instance clips
    votes = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 31, 31, 31, 31};
    launch(4);
    run_conv("v5", 4075, OS ? 137 : 17, 1'b0);
    check_value("v5 saturated result", {20'd0, s_result}, 32'd4095);
    check_value("v5 switches", {2'd0, pswitch_out, nswitch_out}, 32'h3FFF_8000);
    consume("v5");

    // V6: a=7 clamps to 5 (OSR 63, need 32 ones); 31 rejects, 32 accepts
    votes = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 32, 0, 63};
    launch(7);
    run_conv("v6", OS ? 2053 : 2059, OS ? 265 : 17, 1'b0);
    check_value("v6 pswitch", {17'd0, pswitch_out}, OS ? 32'h4005 : 32'h400D);
    consume("v6");

    // Continuous mode, consumer stalled: second HOLD overwrites and flags overrun
    votes = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    set_avg(0);
    continuous_in = 1'b1;
    run_conv("cont1", 2048, 17, 1'b0);
    votes = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_conv("cont2", 806, 17, 1'b1);
    continuous_in = 1'b0;
    consume("cont");
    check_value("cont overrun sticky", {31'd0, overrun_out}, 32'd1);
    check_value("cont idle after hold", {31'd0, busy_out}, 32'd0);

    // Asynchronous reset in the middle of CONVERT
    votes = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    launch(0);
    @(posedge clk);
    @(negedge clk);
    start_in = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      comparator_in = 1'b1;
    end
    check_value("mid-convert enable", {31'd0, enable_loop_out}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_value("rst busy/strobe/enable", {29'd0, busy_out, strobe, enable_loop_out}, 32'd0);
    check_value("rst sample pair", {30'd0, sample_out, sample_out_n}, 32'd1);
    check_value("rst switches", {2'd0, pswitch_out, nswitch_out}, 32'd0);
    check_value("rst result/valid/ovr", {18'd0, result_out, result_valid_out, overrun_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    comparator_in = 1'b0;
    repeat (5) @(negedge clk);
    check_value("idle holds after rst", {31'd0, busy_out}, 32'd0);

    // Recovery: a fresh single shot still works
    votes = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    launch(0);
    run_conv("post-rst", 2048, 17, 1'b0);
    consume("post-rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
